// File: rtl/inst_axi_bridge.sv
// Bridges the IF-stage SRAM-like fetch port onto a single-beat AXI read master.
// Only one read is outstanding at a time. A flush drops the response of the read in flight.
module inst_axi_bridge #(
  parameter logic [3:0] ARID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        inst_sram_en,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        discard_q, discard_d;

  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0;
      size_q    <= 2'b00;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      discard_q <= discard_d;
    end
  end

  // The discard flag ends with the R handshake it belongs to, so a flush
  // that coincides with that handshake does not leak into the next read.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    discard_d = discard_q;
    case (state_q)
      IDLE: begin
        if (inst_sram_en) begin
          state_d = AR;
          addr_d  = inst_sram_addr;
          size_d  = inst_sram_size;
        end
      end
      AR: begin
        if (flush) discard_d = 1'b1;
        if (arready) state_d = R;
      end
      R: begin
        if (flush) discard_d = 1'b1;
        if (rvalid) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_sram_addr_ok = (state_q == IDLE) & ~reset;
  assign inst_sram_data_ok = (state_q == R) & rvalid & ~discard_q & ~flush & ~reset;
  assign inst_sram_rdata   = rdata;

  assign arid    = ARID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (state_q == AR);
  assign rready  = (state_q == R);

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Scoreboard bench for inst_axi_bridge: directed fetches with hand-computed data,
// flush/reset corner cases, then 100 back-to-back fetches with random handshake delays.
module tb_inst_axi_bridge;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        inst_sram_en;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int pass_count = 0;
  int check_count = 0;

  logic [31:0] data_exp[$];
  logic [34:0] ar_exp[$];

  inst_axi_bridge #(.ARID(4'd0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inst_sram_en(inst_sram_en), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every AR handshake and every data_ok is matched against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] d;
    logic [34:0] a;
    if (!reset) begin
      if (inst_sram_data_ok) begin
        if (data_exp.size() == 0) begin
          check_count++;
          $display("[TB] FAIL unexpected_data_ok: got rdata 0x%08h, expected no response", inst_sram_rdata);
        end else begin
          d = data_exp.pop_front();
          checkOutput("mon_rdata", inst_sram_rdata, d);
        end
      end
      if (arvalid && arready) begin
        if (ar_exp.size() == 0) begin
          check_count++;
          $display("[TB] FAIL unexpected_ar: got araddr 0x%08h, expected no request", araddr);
        end else begin
          a = ar_exp.pop_front();
          checkOutput("mon_araddr", araddr, a[31:0]);
          checkOutput("mon_arsize", {29'h0, arsize}, {29'h0, a[34:32]});
        end
      end
      if (inst_sram_addr_ok && inst_sram_data_ok)
        checkOutput("addr_ok_and_data_ok", 32'h1, 32'h0);
    end
  end

  // flush_mode: 0 none, 1 flush first AR cycle, 2 flush with rvalid,
  // 3 flush held over AR and R, 4 flush in the accepting IDLE cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input int ar_wait, input int r_wait, input int flush_mode);
    bit discarded;
    discarded = (flush_mode == 1) || (flush_mode == 2) || (flush_mode == 3);
    checkOutput("idle_addr_ok", {31'h0, inst_sram_addr_ok}, 32'h1);
    inst_sram_en   = 1'b1;
    inst_sram_addr = addr;
    inst_sram_size = 2'b10;
    flush          = (flush_mode == 4);
    ar_exp.push_back({3'b010, addr});
    tick();
    inst_sram_en   = 1'b0;
    inst_sram_addr = 32'h0;
    for (int c = 0; c <= ar_wait; c++) begin
      arready = (c == ar_wait);
      flush   = (flush_mode == 3) || (flush_mode == 1 && c == 0);
      #1;
      checkOutput("ar_arvalid", {31'h0, arvalid}, 32'h1);
      checkOutput("ar_araddr", araddr, addr);
      checkOutput("ar_arsize", {29'h0, arsize}, 32'h2);
      checkOutput("ar_addr_ok", {31'h0, inst_sram_addr_ok}, 32'h0);
      tick();
    end
    arready = 1'b0;
    for (int c = 0; c <= r_wait; c++) begin
      rvalid = (c == r_wait);
      rdata  = rvalid ? data : 32'h5555_0000 + c;
      flush  = (flush_mode == 3) || (flush_mode == 2 && c == r_wait);
      if (rvalid && !discarded) data_exp.push_back(data);
      #1;
      checkOutput("r_rready", {31'h0, rready}, 32'h1);
      checkOutput("r_addr_ok", {31'h0, inst_sram_addr_ok}, 32'h0);
      checkOutput("r_data_ok", {31'h0, inst_sram_data_ok}, rvalid ? {31'h0, !discarded} : 32'h0);
      tick();
    end
    rvalid = 1'b0;
    flush  = 1'b0;
    #1;
    checkOutput("post_addr_ok", {31'h0, inst_sram_addr_ok}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; inst_sram_en = 1'b0; inst_sram_size = 2'b10;
    inst_sram_addr = 32'h0; arready = 1'b0; rid = 4'h0; rdata = 32'h0;
    rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    #2;
    checkOutput("rst_addr_ok", {31'h0, inst_sram_addr_ok}, 32'h0);
    checkOutput("rst_arvalid", {31'h0, arvalid}, 32'h0);
    checkOutput("rst_rready", {31'h0, rready}, 32'h0);
    checkOutput("rst_data_ok", {31'h0, inst_sram_data_ok}, 32'h0);
    checkOutput("rst_araddr", araddr, 32'h0);
    checkOutput("rst_arsize", {29'h0, arsize}, 32'h0);
    checkOutput("rst_arlen", {24'h0, arlen}, 32'h0);
    checkOutput("rst_arburst", {30'h0, arburst}, 32'h1);
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    checkOutput("first_addr_ok", {31'h0, inst_sram_addr_ok}, 32'h1);

    applyStimulus(32'hbfc0_0000, 32'h3c1d_0001, 0, 0, 0);
    applyStimulus(32'hbfc0_0004, 32'h2408_0001, 5, 1, 0);
    applyStimulus(32'hbfc0_0008, 32'hdead_beef, 0, 2, 1);
    applyStimulus(32'hbfc0_0380, 32'h4080_6000, 0, 0, 0);
    applyStimulus(32'hbfc0_000c, 32'hdead_beef, 1, 1, 2);
    applyStimulus(32'hbfc0_0010, 32'hcafe_f00d, 2, 2, 3);
    applyStimulus(32'hbfc0_0014, 32'h1122_3344, 0, 0, 4);

    // Reset pulsed while the read waits in R.
    inst_sram_en = 1'b1; inst_sram_addr = 32'h1fc0_0100; inst_sram_size = 2'b10;
    ar_exp.push_back({3'b010, 32'h1fc0_0100});
    tick();
    inst_sram_en = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    checkOutput("pre_rst_rready", {31'h0, rready}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_arvalid", {31'h0, arvalid}, 32'h0);
    checkOutput("mid_rst_rready", {31'h0, rready}, 32'h0);
    checkOutput("mid_rst_addr_ok", {31'h0, inst_sram_addr_ok}, 32'h0);
    #1 reset = 1'b0;
    tick();
    rvalid = 1'b1; rdata = 32'h0bad_f00d;
    #1;
    checkOutput("stray_data_ok", {31'h0, inst_sram_data_ok}, 32'h0);
    tick();
    rvalid = 1'b0;

    for (int i = 0; i < 100; i++) begin
      int mode;
      mode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      applyStimulus(32'h8000_0000 + 32'(i) * 4, 32'ha5a5_0000 ^ 32'(i * 7 + 1),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), mode);
    end

    tick();
    checkOutput("data_queue_empty", 32'(data_exp.size()), 32'h0);
    checkOutput("ar_queue_empty", 32'(ar_exp.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
